// File: rtl/fetch_stage_sramlike_pkg.sv
// rtl/fetch_stage_sramlike_pkg.sv - shared widths, reset PC, SRAM size encoding and FIFO entry type
package fetch_stage_sramlike_pkg;
  localparam int          WIDTH_BR_BUS       = 34;
  localparam int          WIDTH_FS_TO_DS_BUS = 64;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h1C000000;
  localparam logic [1:0]  SIZE_WORD          = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order fetch FIFO with separate allocate, fill and pop pointers
module fetch_fifo
  import fetch_stage_sramlike_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_alloc,
  input  logic [31:0]   i_alloc_pc,
  input  logic          i_fill,
  input  logic [31:0]   i_fill_inst,
  input  logic          i_pop,
  output logic          o_head_filled,
  output logic [31:0]   o_head_pc,
  output logic [31:0]   o_head_inst,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_unfilled
);
  fetch_entry_t  r_entry [DEPTH];
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_fptr;
  logic [PW-1:0] r_head;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_unfilled;

  // Responses return in order, so the fill pointer always trails the tail
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_tail     <= '0;
      r_fptr     <= '0;
      r_head     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      for (int i = 0; i < DEPTH; i++) r_entry[i].filled <= 1'b0;
    end else begin
      if (i_alloc) begin
        r_entry[r_tail].pc     <= i_alloc_pc;
        r_entry[r_tail].filled <= 1'b0;
        r_tail                 <= r_tail + 1'b1;
      end
      if (i_fill) begin
        r_entry[r_fptr].inst   <= i_fill_inst;
        r_entry[r_fptr].filled <= 1'b1;
        r_fptr                 <= r_fptr + 1'b1;
      end
      if (i_pop) begin
        r_entry[r_head].filled <= 1'b0;
        r_head                 <= r_head + 1'b1;
      end
      r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
    end
  end

  assign o_head_filled = r_entry[r_head].filled;
  assign o_head_pc     = r_entry[r_head].pc;
  assign o_head_inst   = r_entry[r_head].inst;
  assign o_count       = r_count;
  assign o_unfilled    = r_unfilled;
endmodule

// File: rtl/fetch_stage_sramlike.sv
// rtl/fetch_stage_sramlike.sv - SRAM-like (addr_ok/data_ok) instruction fetch stage with stale-response discard
// Optional macro FS_PERF_CNT_EN adds perf_fetch_stall / perf_discard counters.
module fetch_stage_sramlike
  import fetch_stage_sramlike_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter int          BR_BUS_W   = WIDTH_BR_BUS,
  parameter int          FS_TO_DS_W = WIDTH_FS_TO_DS_BUS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ds_allow_in,
  input  logic [BR_BUS_W-1:0]   br_bus,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  output logic                  fs_to_ds_valid,
  output logic [FS_TO_DS_W-1:0] fs_to_ds_bus,
  output logic                  inst_sram_req,
  output logic                  inst_sram_wr,
  output logic [1:0]            inst_sram_size,
  output logic [3:0]            inst_sram_wstrb,
  output logic [31:0]           inst_sram_addr,
  output logic [31:0]           inst_sram_wdata,
  input  logic                  inst_sram_addr_ok,
  input  logic                  inst_sram_data_ok,
  input  logic [31:0]           inst_sram_rdata
`ifdef FS_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_stall,
  output logic [31:0]           perf_discard
`endif
);
  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = FIFO_DEPTH[CW:0];

  logic          w_br_stall;
  logic          w_br_taken;
  logic [31:0]   w_br_target;
  logic          w_cancel;
  logic [31:0]   w_target;
  logic          w_req;
  logic          w_hs;
  logic          w_drop;
  logic          w_fill;
  logic          w_alloc;
  logic          w_pop;
  logic          w_head_filled;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_inst;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_unfilled;
  logic [CW:0]   w_alloc_cnt;
  logic [CW-1:0] w_discard_next;

  logic [31:0]   r_pf_pc;
  logic          r_pf_stale;
  logic [31:0]   r_stale_target;
  logic          r_req_hold;
  logic [CW-1:0] r_discard;

  assign w_br_stall  = br_bus[BR_BUS_W-1];
  assign w_br_taken  = br_bus[BR_BUS_W-2];
  assign w_br_target = br_bus[31:0];
  assign w_cancel    = flush || w_br_taken;
  assign w_target    = flush ? flush_pc : w_br_target;

  // Stale in-flight responses still occupy a slot until they drain
  assign w_alloc_cnt = {1'b0, w_count} + {1'b0, r_discard};
  assign w_req       = !reset && (r_req_hold || (!w_br_stall && (w_alloc_cnt < DEPTH_V)));
  assign w_hs        = w_req && inst_sram_addr_ok;
  assign w_drop      = inst_sram_data_ok && (r_discard != '0);
  assign w_fill      = inst_sram_data_ok && !w_drop && !w_cancel;
  assign w_alloc     = w_hs && !r_pf_stale && !w_cancel;

  assign fs_to_ds_valid = w_head_filled && !w_cancel;
  assign fs_to_ds_bus   = {w_head_inst, w_head_pc};
  assign w_pop          = fs_to_ds_valid && ds_allow_in;

  assign inst_sram_req   = w_req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = r_pf_pc;
  assign inst_sram_wdata = 32'h0;

  // On cancel every unfilled entry becomes a discard; a same-cycle response consumes one of them
  always_comb begin
    w_discard_next = r_discard;
    if (w_cancel)
      w_discard_next = r_discard + w_unfilled + CW'(w_hs) - CW'(inst_sram_data_ok);
    else
      w_discard_next = r_discard - CW'(w_drop) + CW'(w_hs && r_pf_stale);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pf_pc        <= RESET_PC;
      r_pf_stale     <= 1'b0;
      r_stale_target <= '0;
      r_req_hold     <= 1'b0;
      r_discard      <= '0;
    end else begin
      assert (!(inst_sram_data_ok && (r_discard == '0) && (w_unfilled == '0)));
      r_req_hold <= w_req && !inst_sram_addr_ok;
      r_discard  <= w_discard_next;
      if (w_cancel) begin
        if (w_req && !inst_sram_addr_ok) begin
          r_pf_stale     <= 1'b1;
          r_stale_target <= w_target;
        end else begin
          r_pf_stale <= 1'b0;
          r_pf_pc    <= w_target;
        end
      end else if (w_hs) begin
        if (r_pf_stale) begin
          r_pf_stale <= 1'b0;
          r_pf_pc    <= r_stale_target;
        end else begin
          r_pf_pc <= r_pf_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_cancel),
    .i_alloc       (w_alloc),
    .i_alloc_pc    (r_pf_pc),
    .i_fill        (w_fill),
    .i_fill_inst   (inst_sram_rdata),
    .i_pop         (w_pop),
    .o_head_filled (w_head_filled),
    .o_head_pc     (w_head_pc),
    .o_head_inst   (w_head_inst),
    .o_count       (w_count),
    .o_unfilled    (w_unfilled)
  );

`ifdef FS_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_discard;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall   <= '0;
      r_perf_discard <= '0;
    end else begin
      if (ds_allow_in && !fs_to_ds_valid) r_perf_stall <= r_perf_stall + 32'd1;
      if (inst_sram_data_ok && ((r_discard != '0) || w_cancel)) r_perf_discard <= r_perf_discard + 32'd1;
    end
  end

  assign perf_fetch_stall = r_perf_stall;
  assign perf_discard     = r_perf_discard;
`endif
endmodule

// File: tb/tb_fetch_stage_sramlike.sv
// tb/tb_fetch_stage_sramlike.sv - directed bench for fetch_stage_sramlike with an in-order SRAM-like memory model
module tb_fetch_stage_sramlike;
  localparam int          DEPTH = 4;
  localparam logic [31:0] PC0   = 32'h1C000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ds_allow_in, br_stall, br_taken, flush;
  logic [31:0] br_target, flush_pc;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
`ifdef FS_PERF_CNT_EN
  logic [31:0] perf_fetch_stall, perf_discard;
`endif

  assign br_bus = {br_stall, br_taken, br_target};

  fetch_stage_sramlike #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .ds_allow_in       (ds_allow_in),
    .br_bus            (br_bus),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
`ifdef FS_PERF_CNT_EN
    ,
    .perf_fetch_stall  (perf_fetch_stall),
    .perf_discard      (perf_discard)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic        allow;
    logic        aok;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] got[$];
  vec_t        vt[6];
  int          cyc, rlat, n_tests, n_fail, stab_err, inst_err;
  logic        aok, s_req, s_valid, prev_pend;
  logic [31:0] s_addr, s_pc, prev_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a + 32'h13;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: present the memory response, sample outputs, then book-keep the handshakes
  task automatic tick();
    logic        hs;
    logic [31:0] ha;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst_of(mq[0].addr);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
    inst_sram_addr_ok = aok;
    #1;
    s_req   = inst_sram_req;
    s_addr  = inst_sram_addr;
    s_valid = fs_to_ds_valid;
    s_pc    = fs_to_ds_bus[31:0];
    hs      = inst_sram_req && inst_sram_addr_ok;
    ha      = inst_sram_addr;
    if (prev_pend && (!inst_sram_req || inst_sram_addr != prev_addr)) stab_err++;
    prev_pend = inst_sram_req && !hs;
    prev_addr = ha;
    if (fs_to_ds_valid && ds_allow_in) begin
      got.push_back(s_pc);
      if (fs_to_ds_bus[63:32] !== inst_of(s_pc)) inst_err++;
    end
    @(posedge clk);
    if (inst_sram_data_ok) void'(mq.pop_front());
    if (hs) mq.push_back('{addr: ha, due: cyc + 1 + rlat});
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_idle();
    ds_allow_in = 1'b1; br_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    flush = 1'b0; flush_pc = 32'h0; aok = 1'b1; rlat = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    mq.delete();
    prev_pend = 1'b0;
    tick();
    tick();
    check("reset_req", 32'(s_req), 32'd0);
    check("reset_valid", 32'(s_valid), 32'd0);
    reset = 1'b0;
    got.delete();
  endtask

  task automatic wait_pcs(input int n, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < 200) begin
      tick();
      k++;
    end
    check({name, "_count"}, 32'(got.size()), 32'(n));
  endtask

  task automatic expect_seq(input logic [31:0] base, input int n, input string name);
    for (int i = 0; i < n && i < got.size(); i++)
      check(name, got[i], base + 32'(4 * i));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; stab_err = 0; inst_err = 0; cyc = 0;
    reset = 1'b1;
    set_idle();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    prev_pend = 1'b0; prev_addr = 32'h0;
    @(negedge clk);

    // Zero-wait streaming: two-cycle fill, then one pc per cycle
    vt[0] = '{1'b1, 1'b1, 1'b1, PC0 + 32'h00, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 1'b1, PC0 + 32'h04, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 1'b1, PC0 + 32'h08, 1'b1, PC0 + 32'h00};
    vt[3] = '{1'b1, 1'b1, 1'b1, PC0 + 32'h0C, 1'b1, PC0 + 32'h04};
    vt[4] = '{1'b1, 1'b1, 1'b1, PC0 + 32'h10, 1'b1, PC0 + 32'h08};
    vt[5] = '{1'b1, 1'b1, 1'b1, PC0 + 32'h14, 1'b1, PC0 + 32'h0C};
    do_reset();
`ifdef FS_PERF_CNT_EN
    check("reset_perf_discard", perf_discard, 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      ds_allow_in = vt[i].allow;
      aok         = vt[i].aok;
      tick();
      check("t1_req", 32'(s_req), 32'(vt[i].exp_req));
      check("t1_addr", s_addr, vt[i].exp_addr);
      check("t1_valid", 32'(s_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) check("t1_pc", s_pc, vt[i].exp_pc);
    end

    // addr_ok withheld for 3 cycles at pc+4
    do_reset();
    tick();
    aok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_req", 32'(s_req), 32'd1);
      check("t2_hold_addr", s_addr, PC0 + 32'h4);
    end
    aok = 1'b1;
    tick();
    check("t2_accept_addr", s_addr, PC0 + 32'h4);
    wait_pcs(4, "t2");
    expect_seq(PC0, 4, "t2_seq");

    // Branch while a request is pending: stale handshake then redirect
    do_reset();
    tick();
    aok = 1'b0; br_taken = 1'b1; br_target = PC0 + 32'h200;
    tick();
    check("t2b_cancel_req", 32'(s_req), 32'd1);
    check("t2b_cancel_addr", s_addr, PC0 + 32'h4);
    aok = 1'b1; br_taken = 1'b0;
    tick();
    check("t2b_stale_addr", s_addr, PC0 + 32'h4);
    tick();
    check("t2b_redirect_addr", s_addr, PC0 + 32'h200);
    wait_pcs(2, "t2b");
    expect_seq(PC0 + 32'h200, 2, "t2b_seq");
`ifdef FS_PERF_CNT_EN
    check("t2b_perf_discard", perf_discard, 32'd2);
`endif

    // Branch with two responses outstanding
    do_reset();
    rlat = 3;
    tick();
    tick();
    br_stall = 1'b1; br_taken = 1'b1; br_target = PC0 + 32'h100;
    tick();
    check("t3_cancel_valid", 32'(s_valid), 32'd0);
    br_stall = 1'b0; br_taken = 1'b0;
    tick();
    check("t3_redirect_req", 32'(s_req), 32'd1);
    check("t3_redirect_addr", s_addr, PC0 + 32'h100);
    wait_pcs(3, "t3");
    expect_seq(PC0 + 32'h100, 3, "t3_seq");
`ifdef FS_PERF_CNT_EN
    check("t3_perf_discard", perf_discard, 32'd2);
`endif

    // ID back-pressure: FIFO fills and req drops
    do_reset();
    ds_allow_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t4_full_req", 32'(s_req), 32'd0);
    check("t4_full_valid", 32'(s_valid), 32'd1);
    check("t4_full_pc", s_pc, PC0);
    ds_allow_in = 1'b1;
    wait_pcs(6, "t4");
    expect_seq(PC0, 6, "t4_seq");

    // flush and br_taken together: flush target wins, no pop in the cancel cycle
    do_reset();
    tick();
    tick();
    flush = 1'b1; flush_pc = PC0 + 32'h8000; br_taken = 1'b1; br_target = PC0 + 32'h100;
    tick();
    check("t5_cancel_valid", 32'(s_valid), 32'd0);
    flush = 1'b0; br_taken = 1'b0;
    tick();
    check("t5_redirect_addr", s_addr, PC0 + 32'h8000);
    wait_pcs(3, "t5");
    expect_seq(PC0 + 32'h8000, 3, "t5_seq");

    // br_stall: no new requests, outstanding ones complete
    do_reset();
    rlat = 2;
    tick();
    tick();
    br_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_stall_req", 32'(s_req), 32'd0);
    end
    br_stall = 1'b0;
    tick();
    check("t6_resume_req", 32'(s_req), 32'd1);
    check("t6_resume_addr", s_addr, PC0 + 32'h8);
    wait_pcs(4, "t6");
    expect_seq(PC0, 4, "t6_seq");

    check("req_stable", 32'(stab_err), 32'd0);
    check("inst_data", 32'(inst_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_stage_sramlike.md
Name: fetch_stage_sramlike

Overview:
- Parametrised instruction-fetch stage for the 5-stage LoongArch pipeline; sits between the instruction memory and the ID stage.
- Replaces the fixed one-cycle SRAM fetch with an SRAM-like request/response interface (addr_ok/data_ok).
- Supports up to FIFO_DEPTH requests in flight and an in-order fetch FIFO.
- Handles branch redirect, exception flush and discard of stale responses.

Parameters:
- RESET_PC, 32'h1C000000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch-FIFO entries (power of 2, 2..8); bounds allocated-plus-in-flight requests.
- BR_BUS_W, 34, width of br_bus = {br_stall, br_taken, br_target[31:0]}.
- FS_TO_DS_W, 64, width of fs_to_ds_bus = {inst[31:0], pc[31:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ds_allow_in  in  1  ID can accept an instruction this cycle
- br_bus  in  BR_BUS_W  {br_stall, br_taken, br_target} from ID
- flush  in  1  exception/ertn flush from WB
- flush_pc  in  32  redirect target on flush
- fs_to_ds_valid  out  1  fs_to_ds_bus valid
- fs_to_ds_bus  out  FS_TO_DS_W  {inst, pc}
- inst_sram_req  out  1  request valid
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'b10
- inst_sram_wstrb  out  4  constant 0
- inst_sram_addr  out  32  request address
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  response valid (in order)
- inst_sram_rdata  in  32  response instruction

Behaviour:
- Reset:
  - inst_sram_req = 0 and fs_to_ds_valid = 0; FIFO empty.
  - discard_cnt = 0; pf_pc = RESET_PC; first request issued the cycle after reset deasserts.
- Issue:
  - inst_sram_req = pf_valid && !br_stall && (alloc_cnt < FIFO_DEPTH) && !reset.
  - Once req is high, it and addr hold stable until addr_ok, including across a cancel.
  - On the req && addr_ok handshake, allocate a FIFO tail entry {pc, filled=0}, then pf_pc += 4.
- Response:
  - On data_ok with discard_cnt > 0: decrement discard_cnt and drop the data.
  - Otherwise: write rdata into the oldest unfilled entry and set filled = 1.
  - data_ok while nothing is outstanding is a protocol error (assertion).
- Output:
  - fs_to_ds_valid = head.filled && !cancel.
  - Pop on fs_to_ds_valid && ds_allow_in. Latency is 2 cycles minimum from addr_ok to fs_to_ds_valid with zero-wait memory.
- Cancel:
  - cancel = flush || br_taken; flush has priority over br_taken.
  - On cancel, clear all FIFO entries.
  - discard_cnt += unfilled entries, minus a same-cycle non-discarded data_ok.
  - If the pending request handshakes in the cancel cycle, it is also counted in discard_cnt.
  - If req is high but not yet accepted: set pf_stale. The eventual handshake is counted in discard_cnt, and pf_pc is then loaded with the target.
  - Otherwise pf_pc = target the next cycle.
- Simultaneous events:
  - data_ok, addr_ok, pop and cancel may coincide; cancel wins over pop, so no pop occurs.
  - alloc_cnt updates are net of all four.
- Boundaries:
  - FIFO full: req = 0.
  - Pointer wrap-around is modulo FIFO_DEPTH.
  - discard_cnt saturates at no value; width is clog2(FIFO_DEPTH)+1.
- Reset mid-operation drops all state. Responses arriving after reset are the memory's responsibility; the bench must also reset the memory.

Optional Feature:
- Macro FS_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_stall[31:0] and perf_discard[31:0].
  - perf_fetch_stall counts cycles with ds_allow_in && !fs_to_ds_valid.
  - perf_discard counts dropped responses.
  - Both reset to 0 and wrap.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package/header:
  - WIDTH_BR_BUS (34) and WIDTH_FS_TO_DS_BUS (64).
  - RESET_PC constant.
  - SRAM size encoding constant SIZE_WORD = 2'b10.
- Sub-module fetch_fifo:
  - Allocate/fill/pop pointers and per-entry {pc, inst, filled}.
  - Exposes unfilled count and clear.

Test Plan:
1. Zero-wait memory, ds_allow_in=1 -> pcs 1C000000, 1C000004, 1C000008 delivered on consecutive cycles after a 2-cycle fill.
2. addr_ok delayed 3 cycles at pc 1C000004 -> req and addr stay 1C000004 until accept; no duplicate or skipped pc.
3. br_taken with target 1C000100 while 2 requests are outstanding -> both responses dropped (perf_discard=2 if enabled). Next delivered pc is 1C000100.
4. ds_allow_in=0 for 5 cycles -> FIFO fills to FIFO_DEPTH and req drops. On release, in-order delivery resumes with no loss.
5. flush (flush_pc=1C008000) and br_taken in the same cycle -> the flush target wins; next delivered pc is 1C008000.
6. br_stall=1 for 4 cycles -> no new req; outstanding responses still complete; issue resumes at the next sequential pc.
